// File: rtl/ram_arb2_pkg.sv
// ram_arb_pkg: shared widths, FSM state and requester id for the ram_arb2 SRAM arbiter
package ram_arb_pkg;
    localparam int AW = 8;
    localparam int DW = 5;
    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;
    typedef logic id_t;
endpackage

// File: rtl/ram_arb2_if.sv
// ram_arb2_if: two-client request bus plus SRAM command port; lock0/lock1 exist only with RAM_ARB_LOCK_EN
interface ram_arb2_if;
    import ram_arb_pkg::*;
    logic req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic busy;
`ifdef RAM_ARB_LOCK_EN
    logic lock0, lock1;
`endif
    modport slave(
        input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
`ifdef RAM_ARB_LOCK_EN
        input lock0, lock1,
`endif
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_cs, ram_we, ram_addr, ram_wdata, busy
    );
    modport master(
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
`ifdef RAM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        input gnt0, gnt1, rvalid0, rvalid1, rdata, ram_cs, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/ram_arb2_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker with optional locked owner
module rr_pick2 import ram_arb_pkg::*; (
    input  logic req0,
    input  logic req1,
    input  id_t  last,
    input  logic lock_vld,
    input  id_t  lock_id,
    output id_t  win,
    output logic any
);
    logic lock_hit;
    always_comb begin
        any = req0 | req1;
        lock_hit = lock_vld && (lock_id ? req1 : req0);
        win = lock_hit ? lock_id : (req0 && req1) ? ~last : req1;
    end
endmodule

// File: rtl/ram_arb2.sv
// ram_arb2: two-requester round-robin sequencer for a single-port registered-read SRAM.
// Define RAM_ARB_LOCK_EN to let a requester holding lock keep ownership across transactions.
module ram_arb2 import ram_arb_pkg::*; (
    input logic clk,
    input logic rst,
    ram_arb2_if.slave bus
);
    state_t state, state_n;
    id_t last, id_q, win, lock_id;
    logic any, lock_vld, take;

    rr_pick2 u_pick (
        .req0(bus.req0), .req1(bus.req1), .last(last),
        .lock_vld(lock_vld), .lock_id(lock_id), .win(win), .any(any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        take = state == IDLE && any;
        state_n = state == IDLE ? (any ? ISSUE : IDLE)
                : state == ISSUE ? (bus.ram_we ? IDLE : RWAIT)
                : IDLE;
    end

    assign bus.busy = state != IDLE;

    // Command fields are registered on entry to ISSUE so the SRAM sees them for exactly that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
            id_q <= 1'b0;
            {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_cs, bus.ram_we} <= '0;
            bus.ram_addr <= '0;
            bus.ram_wdata <= '0;
            bus.rdata <= '0;
        end else begin
            bus.gnt0 <= take && !win;
            bus.gnt1 <= take && win;
            bus.ram_cs <= take;
            bus.ram_we <= take && (win ? bus.we1 : bus.we0);
            bus.rvalid0 <= state == RWAIT && !id_q;
            bus.rvalid1 <= state == RWAIT && id_q;
            if (take) begin
                bus.ram_addr <= win ? bus.addr1 : bus.addr0;
                bus.ram_wdata <= win ? bus.wdata1 : bus.wdata0;
                id_q <= win;
                last <= win;
            end
            if (state == RWAIT) bus.rdata <= bus.ram_rdata;
        end
    end

`ifdef RAM_ARB_LOCK_EN
    logic done;
    assign done = (state == ISSUE && bus.ram_we) || state == RWAIT;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id <= 1'b0;
        end else if (done) begin
            lock_vld <= id_q ? bus.lock1 : bus.lock0;
            lock_id <= id_q;
        end
    end
`else
    assign lock_vld = 1'b0;
    assign lock_id = 1'b0;
`endif
endmodule

// File: tb/tb_ram_arb2.sv
// tb_ram_arb2: scoreboard bench for ram_arb2 with a behavioural 256x5 registered-read SRAM
module tb_ram_arb2;
    typedef struct {logic id; logic we; logic [7:0] a; logic [4:0] d;} g_t;
    typedef struct {logic id; logic [4:0] d;} r_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0, fails = 0, cyc = 0, last_g = 0, prev_g = 0, last_rv = 0;
    g_t gq[$];
    r_t rq[$];
    int tq[$];
    logic [4:0] mem [256];

    ram_arb2_if bif();
    ram_arb2 dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bif.ram_cs) begin
            if (bif.ram_we) mem[bif.ram_addr] <= bif.ram_wdata;
            else bif.ram_rdata <= mem[bif.ram_addr];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic exp_g(input logic id, input logic we, input logic [7:0] a, input logic [4:0] d);
        g_t g;
        g.id = id; g.we = we; g.a = a; g.d = d;
        gq.push_back(g);
    endtask

    task automatic exp_r(input logic id, input logic [4:0] d);
        r_t r;
        r.id = id; r.d = d;
        rq.push_back(r);
    endtask

    task automatic chk_idle(input string tag);
        check(tag, {bif.gnt0, bif.gnt1, bif.rvalid0, bif.rvalid1, bif.ram_cs, bif.ram_we,
                    bif.ram_addr, bif.ram_wdata, bif.rdata, bif.busy}, 0);
    endtask

    // Hold req with stable fields until this client's gnt is seen, then drop it
    task automatic access(input int id, input logic we, input logic [7:0] a, input logic [4:0] d);
        int n = 0;
        logic got;
        if (id == 0) begin bif.we0 = we; bif.addr0 = a; bif.wdata0 = d; bif.req0 = 1'b1; end
        else begin bif.we1 = we; bif.addr1 = a; bif.wdata1 = d; bif.req1 = 1'b1; end
        do begin
            @(posedge clk); #1; n++;
            got = id == 0 ? bif.gnt0 : bif.gnt1;
        end while (!got && n < 40);
        check("gnt_wait", got, 1);
        if (id == 0) bif.req0 = 1'b0; else bif.req1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((gq.size() + rq.size() != 0 || bif.busy) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("drain", gq.size() + rq.size(), 0);
    endtask

    always @(negedge clk) begin
        g_t g;
        r_t r;
        cyc++;
        if (rst) tq.delete();
        else begin
            if (bif.gnt0 || bif.gnt1) begin
                check("gnt_onehot", bif.gnt0 & bif.gnt1, 0);
                check("gnt_cs", bif.ram_cs, 1);
                if (gq.size() == 0) check("gnt_unexpected", {bif.gnt1, bif.gnt0}, 0);
                else begin
                    g = gq.pop_front();
                    check("gnt_id", bif.gnt1, g.id);
                    check("ram_we", bif.ram_we, g.we);
                    check("ram_addr", bif.ram_addr, g.a);
                    if (g.we) check("ram_wdata", bif.ram_wdata, g.d);
                end
                prev_g = last_g;
                last_g = cyc;
                if (!bif.ram_we) tq.push_back(cyc + 2);
            end
            if (bif.rvalid0 || bif.rvalid1) begin
                if (rq.size() == 0) check("rv_unexpected", {bif.rvalid1, bif.rvalid0}, 0);
                else begin
                    r = rq.pop_front();
                    check("rv_id", {bif.rvalid1, bif.rvalid0}, r.id ? 2 : 1);
                    check("rdata", bif.rdata, r.d);
                end
                check("rv_cycle", cyc, tq.size() != 0 ? tq.pop_front() : 0);
                last_rv = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {bif.req0, bif.req1, bif.we0, bif.we1} = '0;
        {bif.addr0, bif.addr1, bif.wdata0, bif.wdata1} = '0;
        bif.ram_rdata = '0;
`ifdef RAM_ARB_LOCK_EN
        bif.lock0 = 1'b0;
        bif.lock1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 chk_idle("reset_outs");
        rst = 1'b0;

        // single write then read by requester 0
        exp_g(0, 1, 8'hA8, 5'd18);
        access(0, 1, 8'hA8, 5'd18);
        exp_g(0, 0, 8'hA8, 5'd0); exp_r(0, 5'd18);
        access(0, 0, 8'hA8, 5'd0);
        drain();

        // make requester 1 the last grant so the tie below goes to 0
        exp_g(1, 1, 8'h00, 5'd3);
        access(1, 1, 8'h00, 5'd3);
        drain();
        exp_g(0, 1, 8'h57, 5'd12);
        exp_g(1, 1, 8'hF3, 5'd18);
        fork
            access(0, 1, 8'h57, 5'd12);
            access(1, 1, 8'hF3, 5'd18);
        join
        drain();
        check("tie_gap", last_g - prev_g, 2);
        exp_g(0, 0, 8'h57, 5'd0); exp_r(0, 5'd12);
        access(0, 0, 8'h57, 5'd0);
        exp_g(1, 0, 8'hF3, 5'd0); exp_r(1, 5'd18);
        access(1, 0, 8'hF3, 5'd0);
        drain();

        // fairness: both held for 8 reads
        for (int i = 0; i < 4; i++) begin
            exp_g(0, 0, 8'h57, 5'd0); exp_r(0, 5'd12);
            exp_g(1, 0, 8'hF3, 5'd0); exp_r(1, 5'd18);
        end
        fork
            for (int i = 0; i < 4; i++) access(0, 0, 8'h57, 5'd0);
            for (int j = 0; j < 4; j++) access(1, 0, 8'hF3, 5'd0);
        join
        drain();

        // read return to requester 1 precedes the waiting write from 0
        exp_g(1, 0, 8'hF3, 5'd0); exp_r(1, 5'd18);
        exp_g(0, 1, 8'h10, 5'd7);
        access(1, 0, 8'hF3, 5'd0);
        access(0, 1, 8'h10, 5'd7);
        drain();
        check("rv_before_gnt0", last_g - last_rv, 1);

        // reset while in RWAIT drops the read
        exp_g(0, 0, 8'h57, 5'd0);
        access(0, 0, 8'h57, 5'd0);
        @(posedge clk); #1;
        check("busy_rwait", bif.busy, 1);
        rst = 1'b1;
        #1 chk_idle("reset_midread");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("pending_after_reset", gq.size() + rq.size(), 0);
        exp_g(0, 1, 8'h20, 5'd1);
        exp_g(1, 1, 8'h21, 5'd2);
        fork
            access(0, 1, 8'h20, 5'd1);
            access(1, 1, 8'h21, 5'd2);
        join
        drain();
        check("mem_20", mem[8'h20], 5'd1);
        check("mem_21", mem[8'h21], 5'd2);

`ifdef RAM_ARB_LOCK_EN
        // locked requester 1 starves 0 until lock1 drops
        for (int i = 0; i < 3; i++) exp_g(1, 1, 8'h30 + 8'(i), 5'(i));
        exp_g(0, 1, 8'h40, 5'd4);
        bif.lock1 = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) access(1, 1, 8'h30 + 8'(i), 5'(i));
                bif.lock1 = 1'b0;
            end
            begin
                int n = 0;
                do begin @(posedge clk); #1; n++; end while (!bif.gnt1 && n < 40);
                access(0, 1, 8'h40, 5'd4);
            end
        join
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
